// File: rtl/lcd_rx_pkg.sv
// Shared types and helpers for the HD44780-style LCD receive decoder:
// FSM states, command classes and DDRAM address-counter mapping.
package lcd_rx_pkg;

  localparam int         DDRAM_DEPTH = 80;
  localparam logic [6:0] LINE1_LAST  = 7'h27;
  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam logic [6:0] LINE2_LAST  = 7'h67;
  localparam logic [7:0] BLANK_CHAR  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_CLEAR = 4'd1,
    CMD_HOME  = 4'd2,
    CMD_ENTRY = 4'd3,
    CMD_DISP  = 4'd4,
    CMD_SHIFT = 4'd5,
    CMD_FUNC  = 4'd6,
    CMD_CGRAM = 4'd7,
    CMD_DDRAM = 4'd8
  } cmd_class_e;

  // Commands are classified by their highest set bit.
  function automatic cmd_class_e cmd_class(input logic [7:0] b);
    cmd_class_e c;
    casez (b)
      8'b1???_????: c = CMD_DDRAM;
      8'b01??_????: c = CMD_CGRAM;
      8'b001?_????: c = CMD_FUNC;
      8'b0001_????: c = CMD_SHIFT;
      8'b0000_1???: c = CMD_DISP;
      8'b0000_01??: c = CMD_ENTRY;
      8'b0000_001?: c = CMD_HOME;
      8'b0000_0001: c = CMD_CLEAR;
      default:      c = CMD_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] ac_to_idx(input logic [6:0] ac);
    return (ac < LINE2_BASE) ? ac : (ac - 7'h18);
  endfunction

  function automatic logic ac_valid(input logic [6:0] ac);
    return (ac <= LINE1_LAST) || ((ac >= LINE2_BASE) && (ac <= LINE2_LAST));
  endfunction

  // Line 1 ends at 0x27 and continues at 0x40; line 2 ends at 0x67 and wraps to 0x00.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (ac == LINE1_LAST)      n = LINE2_BASE;
      else if (ac == LINE2_LAST) n = 7'h00;
      else                       n = ac + 7'd1;
    end else begin
      if (ac == LINE2_BASE)      n = LINE1_LAST;
      else if (ac == 7'h00)      n = LINE2_LAST;
      else                       n = ac - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_rx_if.sv
// LCD parallel bus: host drives DATA/RS/RW/EN, the receiver returns readback data.
interface lcd_rx_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_dq_out;
  logic       lcd_dq_oe;

  modport master (output lcd_data, lcd_rs, lcd_rw, lcd_en, input lcd_dq_out, lcd_dq_oe);
  modport slave  (input lcd_data, lcd_rs, lcd_rw, lcd_en, output lcd_dq_out, lcd_dq_oe);
endinterface

// File: rtl/lcd_rx_sync.sv
// Two-flop synchronizer for the 11-bit LCD bus {data, rs, rw, en} with
// EN rise/fall pulse generation on the synchronized strobe.
module lcd_rx_sync (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] bus_i,
  output logic [9:0]  ctrl_o,
  output logic        en_rise_o,
  output logic        en_fall_o
);

  logic [10:0] meta_q;
  logic [10:0] sync_q;
  logic        en_prev_q;

  // Synchronizer stages plus delayed EN for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 11'd0;
      sync_q    <= 11'd0;
      en_prev_q <= 1'b0;
    end else begin
      meta_q    <= bus_i;
      sync_q    <= meta_q;
      en_prev_q <= sync_q[0];
    end
  end

  assign ctrl_o    = sync_q[10:1];
  assign en_rise_o = sync_q[0] & ~en_prev_q;
  assign en_fall_o = ~sync_q[0] & en_prev_q;

endmodule

// File: rtl/lcd_rx_decoder.sv
// HD44780-style LCD receiver: DDRAM image, address counter, flags and busy emulation.
// Optional status readback (RW=1, RS=0) is enabled with the LCD_RX_READBACK_EN macro.
module lcd_rx_decoder
  import lcd_rx_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_rx_if.slave    bus,
  input  logic [6:0] rd_addr_i,
  output logic [7:0] rd_char_o,
  output logic [6:0] ac_o,
  output logic       disp_on_o,
  output logic       two_line_o,
  output logic       busy_o,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_byte_o,
  output logic       protocol_err_o
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [6:0]       LAST_IDX   = 7'(DDRAM_DEPTH - 1);

  logic [9:0] ctrl_s;
  logic       en_rise_s, en_fall_s;
  logic [7:0] s_data;
  logic       s_rs, s_rw;

  lcd_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_i     ({bus.lcd_data, bus.lcd_rs, bus.lcd_rw, bus.lcd_en}),
    .ctrl_o    (ctrl_s),
    .en_rise_o (en_rise_s),
    .en_fall_o (en_fall_s)
  );

  assign s_data = ctrl_s[9:2];
  assign s_rs   = ctrl_s[1];
  assign s_rw   = ctrl_s[0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       clr_idx_q, clr_idx_d;
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d, disp_on_q, disp_on_d, two_line_q, two_line_d;
  logic             cgram_q, cgram_d, busy_q, busy_d;
  logic             cmd_valid_q, cmd_valid_d, perr_q, perr_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d, dq_out_q, dq_out_d;
  logic             dq_oe_q, dq_oe_d;
  logic             acc_s, long_s, clr_s;
  logic             img_we_s;
  logic [6:0]       img_waddr_s;
  logic [7:0]       img_wdata_s;
  logic [7:0]       image_q [DDRAM_DEPTH];
  logic [7:0]       rd_char_q;

  // Next-state: clear sweep, busy countdown and transfer decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_idx_d   = clr_idx_q;
    ac_d        = ac_q;
    id_d        = id_q;
    disp_on_d   = disp_on_q;
    two_line_d  = two_line_q;
    cgram_d     = cgram_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    perr_d      = 1'b0;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    acc_s       = 1'b0;
    long_s      = 1'b0;
    clr_s       = 1'b0;
    img_we_s    = 1'b0;
    img_waddr_s = clr_idx_q;
    img_wdata_s = BLANK_CHAR;

    case (state_q)
      ST_CLEAR: begin
        img_we_s = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_BUSY;
          cnt_d     = CLEAR_LOAD;
          clr_idx_d = 7'd0;
        end else begin
          clr_idx_d = clr_idx_q + 7'd1;
        end
      end
      ST_BUSY: begin
        if (cnt_q == {CNT_W{1'b0}}) state_d = ST_IDLE;
        else                        cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IDLE: state_d = ST_IDLE;
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = 7'd0;
      end
    endcase

    if (en_fall_s) begin
      dq_oe_d = 1'b0;
      if (s_rw) begin
`ifdef LCD_RX_READBACK_EN
        perr_d = s_rs;
`else
        perr_d = 1'b1;
`endif
      end else if (state_q != ST_IDLE) begin
        perr_d = 1'b1;
      end else if (s_rs) begin
        acc_s = 1'b1;
        // Data after a CGRAM address set is swallowed until DDRAM is re-addressed.
        if (!cgram_q) begin
          img_we_s    = 1'b1;
          img_waddr_s = ac_to_idx(ac_q);
          img_wdata_s = s_data;
          ac_d        = ac_step(ac_q, id_q);
        end else begin
          ac_d = ac_q;
        end
      end else begin
        case (cmd_class(s_data))
          CMD_CLEAR: begin
            acc_s = 1'b1; clr_s = 1'b1;
            state_d = ST_CLEAR; clr_idx_d = 7'd0;
            ac_d = 7'd0; id_d = 1'b1; cgram_d = 1'b0;
          end
          CMD_HOME: begin
            acc_s = 1'b1; long_s = 1'b1;
            ac_d = 7'd0; cgram_d = 1'b0;
          end
          CMD_ENTRY: begin
            id_d   = s_data[1];
            acc_s  = ~s_data[0];
            perr_d = s_data[0];
          end
          CMD_DISP: begin
            acc_s = 1'b1; disp_on_d = s_data[2];
          end
          CMD_SHIFT: begin
            if (s_data[3]) perr_d = 1'b1;
            else begin acc_s = 1'b1; ac_d = ac_step(ac_q, s_data[2]); end
          end
          CMD_FUNC: begin
            if (!s_data[4]) perr_d = 1'b1;
            else begin acc_s = 1'b1; two_line_d = s_data[3]; end
          end
          CMD_CGRAM: begin
            acc_s = 1'b1; cgram_d = 1'b1;
          end
          CMD_DDRAM: begin
            if (ac_valid(s_data[6:0])) begin
              acc_s = 1'b1; ac_d = s_data[6:0]; cgram_d = 1'b0;
            end else begin
              perr_d = 1'b1;
            end
          end
          default: perr_d = 1'b1;
        endcase
      end
      if (acc_s) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = s_data;
        if (!clr_s) begin
          state_d = ST_BUSY;
          cnt_d   = long_s ? CLEAR_LOAD : BUSY_LOAD;
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        cmd_byte_d = cmd_byte_q;
      end
    end else begin
`ifdef LCD_RX_READBACK_EN
      if (en_rise_s && s_rw && !s_rs) begin
        dq_oe_d  = 1'b1;
        dq_out_d = {busy_q, ac_q};
      end else begin
        dq_oe_d = dq_oe_q;
      end
`else
      dq_oe_d = 1'b0;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

`ifndef LCD_RX_READBACK_EN
  logic unused_rise_s;
  assign unused_rise_s = en_rise_s;
`endif

  // Control and status registers; reset restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= {CNT_W{1'b0}};
      clr_idx_q   <= 7'd0;
      ac_q        <= 7'd0;
      id_q        <= 1'b1;
      disp_on_q   <= 1'b0;
      two_line_q  <= 1'b0;
      cgram_q     <= 1'b0;
      busy_q      <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'd0;
      perr_q      <= 1'b0;
      dq_out_q    <= 8'd0;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_idx_q   <= clr_idx_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      disp_on_q   <= disp_on_d;
      two_line_q  <= two_line_d;
      cgram_q     <= cgram_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      perr_q      <= perr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  // DDRAM image storage; contents are initialised by the clear sweep.
  always_ff @(posedge clk) begin
    if (img_we_s) image_q[img_waddr_s] <= img_wdata_s;
  end

  // Registered read port: a same-cycle write to the read index returns the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                rd_char_q <= 8'd0;
    else if (rd_addr_i < 7'(DDRAM_DEPTH))      rd_char_q <= image_q[rd_addr_i];
    else                                       rd_char_q <= BLANK_CHAR;
  end

  assign rd_char_o      = rd_char_q;
  assign ac_o           = ac_q;
  assign disp_on_o      = disp_on_q;
  assign two_line_o     = two_line_q;
  assign busy_o         = busy_q;
  assign cmd_valid_o    = cmd_valid_q;
  assign cmd_byte_o     = cmd_byte_q;
  assign protocol_err_o = perr_q;
  assign bus.lcd_dq_out = dq_out_q;
  assign bus.lcd_dq_oe  = dq_oe_q;

endmodule
